// File: rtl/shim_release_ctrl.sv
// Release controller for a 66b shim queue.
// Decides when the head of the queue may be read out.
module shim_release_ctrl #(
  parameter int DATA_W    = 64,
  parameter int PKT_CNT_W = 4,
  parameter int OCC_W     = 6,
  parameter int CT_THRESH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic                 hold,
  input  logic                 shim_in_valid,
  input  logic [1:0]           shim_inc,
  input  logic [DATA_W-1:0]    shim_ind,
  input  logic                 shim_out_valid,
  input  logic [1:0]           shim_outc,
  input  logic [DATA_W-1:0]    shim_outd,
  output logic                 shimq_read,
  output logic [PKT_CNT_W-1:0] pkt_count,
  output logic [OCC_W-1:0]     occupancy,
  output logic                 err_overflow,
  output logic                 err_underrun
);

  typedef enum logic {
    IDLE    = 1'b0,
    RELEASE = 1'b1
  } state_e;

  localparam logic [PKT_CNT_W-1:0] PKT_MAX = '1;
  localparam logic [OCC_W-1:0]     OCC_MAX = '1;
  localparam logic [OCC_W-1:0]     CT_OCC  = OCC_W'(CT_THRESH);

  state_e               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [1:0]           mode_eff;
  logic                 rd_q, rd_d;
  logic [PKT_CNT_W-1:0] pkt_q, pkt_d;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic                 ovf_q, ovf_d;
  logic                 und_q, und_d;
  logic                 wr, wr_term;
  logic                 rd, rd_term;
  logic                 go;
  logic                 unused_hi;

  function automatic logic is_term(input logic [1:0] c,
                                   input logic [7:0] b);
    return (c == 2'b01) &&
           (b inside {8'h87, 8'h99, 8'hAA, 8'hB4,
                      8'hCC, 8'hD2, 8'hE1, 8'hFF});
  endfunction

  assign unused_hi = ^{shim_ind[DATA_W-1:8], shim_outd[DATA_W-1:8]};

  assign wr      = shim_in_valid;
  assign wr_term = wr && is_term(shim_inc, shim_ind[7:0]);
  assign rd      = rd_q && shim_out_valid;
  assign rd_term = rd && is_term(shim_outc, shim_outd[7:0]);

  // Word/packet counters and sticky error flags
  always_comb begin
    occ_d = occ_q;
    pkt_d = pkt_q;
    ovf_d = ovf_q;
    und_d = und_q;
    if (wr && !rd) begin
      if (occ_q == OCC_MAX) ovf_d = 1'b1;
      else                  occ_d = occ_q + OCC_W'(1);
    end else if (rd && !wr) begin
      if (occ_q != '0) occ_d = occ_q - OCC_W'(1);
    end
    if (wr_term && !rd_term) begin
      if (pkt_q == PKT_MAX) ovf_d = 1'b1;
      else                  pkt_d = pkt_q + PKT_CNT_W'(1);
    end else if (rd_term && !wr_term) begin
      if (pkt_q != '0) pkt_d = pkt_q - PKT_CNT_W'(1);
    end
    if (mode_q == 2'd1 && state_q == RELEASE &&
        rd_q && !shim_out_valid)
      und_d = 1'b1;
  end

  // Next state and mode latch
  always_comb begin
    mode_eff = (mode == 2'd3) ? 2'd0 : mode;
    mode_d   = mode_q;
    state_d  = state_q;
    go       = 1'b0;
    unique case (state_q)
      IDLE: begin
        mode_d = mode_eff;
        unique case (1'b1)
          (mode_eff == 2'd2): go = 1'b1;
          (mode_eff == 2'd1): go = (occ_q >= CT_OCC) ||
                                   (pkt_q != '0);
          default:            go = (pkt_q != '0);
        endcase
        if (go && !hold) state_d = RELEASE;
      end
      RELEASE: begin
        if (mode_q != 2'd2 && rd_term && pkt_d == '0)
          state_d = IDLE;
      end
    endcase
  end

  // Registered read enable
  always_comb begin
    rd_d = (state_d == RELEASE) && !hold;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 2'd0;
      rd_q    <= 1'b0;
      pkt_q   <= '0;
      occ_q   <= '0;
      ovf_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rd_q    <= rd_d;
      pkt_q   <= pkt_d;
      occ_q   <= occ_d;
      ovf_q   <= ovf_d;
      und_q   <= und_d;
    end
  end

  assign shimq_read   = rd_q;
  assign pkt_count    = pkt_q;
  assign occupancy    = occ_q;
  assign err_overflow = ovf_q;
  assign err_underrun = und_q;

endmodule

// File: doc/shim_release_ctrl.md
SHIM_RELEASE_CTRL -- requirements
Module: shim_release_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 64, shim data width in bits (multiple of 8, >= 64).
REQ-002 SHALL have parameter PKT_CNT_W, default 4, width of the buffered-packet counter.
REQ-003 SHALL have parameter OCC_W, default 6, width of the queue occupancy counter.
REQ-004 SHALL have parameter CT_THRESH, default 8, occupancy in words that starts cut-through release.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port mode, input, 2, release mode: 0 store-and-forward, 1 cut-through, 2 always-on, 3 reserved (treated as 0).
REQ-008 SHALL have port hold, input, 1, pause request; it suppresses reads without losing state.
REQ-009 SHALL have port shim_in_valid, input, 1, queue write strobe.
REQ-010 SHALL have port shim_inc, input, 2, 66b sync header of the written word.
REQ-011 SHALL have port shim_ind, input, DATA_W, data of the written word.
REQ-012 SHALL have port shim_out_valid, input, 1, queue head word valid (first-word-fall-through).
REQ-013 SHALL have port shim_outc, input, 2, sync header of the head word.
REQ-014 SHALL have port shim_outd, input, DATA_W, data of the head word.
REQ-015 SHALL have port shimq_read, output, 1, registered queue read enable.
REQ-016 SHALL have port pkt_count, output, PKT_CNT_W, complete packets held in the queue.
REQ-017 SHALL have port occupancy, output, OCC_W, words held in the queue.
REQ-018 SHALL have ports err_overflow and err_underrun, output, 1 each, sticky error flags.

Function
REQ-019 A terminate word SHALL be sync 2'b01 with data[7:0] in {87,99,AA,B4,CC,D2,E1,FF} hex; a data word is sync 2'b10.
REQ-020 A write SHALL be shim_in_valid=1; a read SHALL be shimq_read=1 and shim_out_valid=1 in the same cycle.
REQ-021 occupancy SHALL add 1 per write and subtract 1 per read, net 0 when both occur; saturate at max (set err_overflow) and at 0.
REQ-022 pkt_count SHALL add 1 per written terminate and subtract 1 per read terminate, net 0 when both occur; saturate at max (set err_overflow) and hold at 0.
REQ-023 FSM states SHALL be IDLE and RELEASE; effective mode SHALL be latched from mode only while in IDLE.
REQ-024 IDLE->RELEASE SHALL occur when hold=0 and one of: mode 0 with pkt_count>0; mode 1 with occupancy>=CT_THRESH or pkt_count>0; mode 2 unconditionally.
REQ-025 RELEASE->IDLE SHALL occur on a read terminate when the next pkt_count is 0 (modes 0 and 1); mode 2 SHALL never leave RELEASE except by reset.
REQ-026 shimq_read SHALL be registered: next value is 1 iff next state is RELEASE and hold=0; latency from qualifying event to shimq_read=1 is one cycle.
REQ-027 A read terminate ending release SHALL produce shimq_read=0 in the immediately following cycle, so no word of the next packet is read.
REQ-028 hold=1 SHALL force shimq_read=0 in the next cycle and keep the FSM state and counters (counters still track writes).
REQ-029 In mode 1 while in RELEASE, shim_out_valid=0 with shimq_read=1 before the terminate has been read SHALL set err_underrun.
REQ-030 Error flags SHALL stay set until reset.

Reset
REQ-031 With rst=1 at a rising edge: state IDLE, effective mode 0, shimq_read=0, pkt_count=0, occupancy=0, err_overflow=0, err_underrun=0.
REQ-032 Reset mid-packet SHALL take priority over every event in that cycle and discard all counts.

Verification
REQ-033 Mode 0: write 5 data words and 1 terminate (0x87) -> pkt_count=1 and shimq_read=1 one cycle later; after 6 reads, pkt_count=0 and shimq_read=0 in the cycle after the terminate.
REQ-034 Mode 0: two packets buffered, read the first terminate -> shimq_read stays 1 and pkt_count goes 2->1.
REQ-035 Mode 1, CT_THRESH=8: write 8 data words without a terminate -> shimq_read=1 one cycle after occupancy reaches 8; emptying the queue before the terminate sets err_underrun.
REQ-036 Same-cycle terminate write and terminate read with pkt_count=1 -> pkt_count stays 1 and release continues.
REQ-037 hold=1 during RELEASE for 3 cycles -> shimq_read=0 for those cycles, and release resumes with counters intact.
REQ-038 rst asserted mid-release with pkt_count=3 -> all outputs zero next cycle; mode 2 then gives shimq_read=1 one cycle after rst falls.
